// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator.
//   led_mode_e : run-time pattern selection presented on the 2-bit `mode` input
//   MODE_W     : width of the mode field
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts enabled cycles and pulses `tick` once every DIV of them.
// Ports:
//   clk   in  system clock (rising edge)
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; low holds the counter and suppresses tick
//   clr   in  synchronous restart of the count from 0 (wins over en)
//   tick  out combinational step strobe, high on the last count of a period
module tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // A 1-bit counter is kept even for DIV=1 so the compare stays well-formed;
  // with DIV=1 it never leaves 0 and every enabled cycle is a tick.
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator with four modes: off, blink, chase and
// breathe (triangle-wave PWM). Pattern steps advance on prescaler ticks.
// Ports:
//   clk   in  system clock (rising edge)
//   rst_n in  asynchronous active-low reset; clears led immediately
//   en    in  run enable; low freezes all state and forces led to 0
//   mode  in  0 off, 1 blink, 2 chase, 3 breathe; sampled every cycle
//   led   out registered active-high LED drive, N_LED wide
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED    = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter int PWM_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  output logic [N_LED-1:0]  led
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [N_LED-1:0]    CHASE_INIT = N_LED'(1);

  led_mode_e           mode_q, mode_d;
  logic                blink_q, blink_d;
  logic [N_LED-1:0]    chase_q, chase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_up_q, dir_up_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_LED-1:0]    led_d;
  logic                mode_chg;
  logic                tick_raw;
  logic                tick;

  // A mode change is seen even while disabled so the new mode is loaded and
  // its pattern restarts from the beginning once enable returns.
  assign mode_chg = (mode != mode_q);

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (mode_chg),
    .tick  (tick_raw)
  );

  // The mode reload takes priority; a tick landing in the same cycle is lost.
  assign tick = tick_raw && !mode_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_OFF;
      blink_q  <= 1'b0;
      chase_q  <= CHASE_INIT;
      duty_q   <= '0;
      dir_up_q <= 1'b1;
      pwm_cnt  <= '0;
      led      <= '0;
    end else begin
      mode_q   <= mode_d;
      blink_q  <= blink_d;
      chase_q  <= chase_d;
      duty_q   <= duty_d;
      dir_up_q <= dir_up_d;
      if (en) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      led      <= led_d;
    end
  end

  // Next-state for the mode register and pattern state.
  always_comb begin
    mode_d   = mode_q;
    blink_d  = blink_q;
    chase_d  = chase_q;
    duty_d   = duty_q;
    dir_up_d = dir_up_q;
    if (mode_chg) begin
      mode_d   = led_mode_e'(mode);
      blink_d  = 1'b0;
      chase_d  = CHASE_INIT;
      duty_d   = '0;
      dir_up_d = 1'b1;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: blink_d = !blink_q;
        MODE_CHASE: chase_d = {chase_q[N_LED-2:0], chase_q[N_LED-1]};
        MODE_BREATHE: begin
          // The direction flips and the step is taken on the same tick, so
          // the triangle never dwells at either extreme.
          if (dir_up_q) begin
            if (duty_q == DUTY_MAX) begin
              dir_up_d = 1'b0;
              duty_d   = duty_q - 1'b1;
            end else begin
              duty_d   = duty_q + 1'b1;
            end
          end else begin
            if (duty_q == '0) begin
              dir_up_d = 1'b1;
              duty_d   = duty_q + 1'b1;
            end else begin
              duty_d   = duty_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output function of the current (pre-update) state.
  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_OFF:     led_d = '0;
      MODE_BLINK:   led_d = {N_LED{blink_q}};
      MODE_CHASE:   led_d = chase_q;
      MODE_BREATHE: led_d = {N_LED{pwm_cnt < duty_q}};
      default:      led_d = '0;
    endcase
    if (!en) begin
      led_d = '0;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances sharing stimulus
//   dut_a : N_LED=4, TICK_DIV=4, PWM_BITS=2
//   dut_b : N_LED=4, TICK_DIV=1, PWM_BITS=3
// A reference model derives each expected LED word from the number of enabled
// cycles since the last mode load and the number of enabled cycles since reset.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'd1;
  logic [3:0] led_a, led_b;

  int checks = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  led_pattern_gen #(.N_LED(4), .TICK_DIV(4), .PWM_BITS(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .led   (led_a)
  );

  led_pattern_gen #(.N_LED(4), .TICK_DIV(1), .PWM_BITS(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .led   (led_b)
  );

  // ---------------- reference model ----------------
  // steps = completed prescaler periods since the load; blink = parity of
  // steps, chase = one-hot at steps mod N, breathe duty = triangle of steps.
  function automatic logic [3:0] ref_led(int div, int pbits, logic [1:0] m,
                                         int c, int pwm);
    int steps;
    int mx;
    int s;
    int duty;
    int ph;
    logic [3:0] r;
    steps = c / div;
    mx    = (1 << pbits) - 1;
    ph    = pwm % (1 << pbits);
    r     = 4'h0;
    case (m)
      2'd1: r = (steps % 2 == 1) ? 4'hF : 4'h0;
      2'd2: r = 4'(1 << (steps % 4));
      2'd3: begin
        s    = steps % (2 * mx);
        duty = (s <= mx) ? s : 2 * mx - s;
        r    = (ph < duty) ? 4'hF : 4'h0;
      end
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  logic [1:0] m_mode;
  int         m_c;
  int         m_pwm;
  logic [3:0] exp_a, exp_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 2'd0;
      m_c    <= 0;
      m_pwm  <= 0;
      exp_a  <= 4'h0;
      exp_b  <= 4'h0;
    end else begin
      exp_a <= en ? ref_led(4, 2, m_mode, m_c, m_pwm) : 4'h0;
      exp_b <= en ? ref_led(1, 3, m_mode, m_c, m_pwm) : 4'h0;
      if (mode != m_mode) begin
        m_mode <= mode;
        m_c    <= 0;
      end else if (en) begin
        m_c <= m_c + 1;
      end
      if (en) m_pwm <= m_pwm + 1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_a"}, led_a, exp_a);
    chk({tag, "_b"}, led_b, exp_b);
  endtask

  logic [3:0] chase_seq [5];

  // ---------------- directed + random sequence ----------------
  initial begin
    chase_seq[0] = 4'b0001;
    chase_seq[1] = 4'b0010;
    chase_seq[2] = 4'b0100;
    chase_seq[3] = 4'b1000;
    chase_seq[4] = 4'b0001;

    // 1. reset, blink
    step("rst");
    step("rst");
    chk("rst_led_a", led_a, 4'h0);
    chk("rst_led_b", led_b, 4'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("t1_dark");
      chk("t1_dark_a", led_a, 4'h0);
    end
    step("t1_on");
    chk("t1_first_on_a", led_a, 4'hF);
    for (int i = 0; i < 3; i++) step("t1_on");
    step("t1_off");
    chk("t1_toggle_off_a", led_a, 4'h0);
    for (int i = 0; i < 6; i++) step("t1");

    // 2. chase wrap on the TICK_DIV=1 instance
    mode = 2'd2;
    step("t2_load");
    for (int i = 0; i < 5; i++) begin
      step("t2");
      chk("t2_chase_seq_b", led_b, chase_seq[i]);
    end

    // 3. breathe triangle over more than a full period of dut_a
    mode = 2'd3;
    for (int i = 0; i < 60; i++) step("t3_breathe");

    // 4. enable freeze: chase reloaded, then 10 enabled cycles reach
    //    pattern 0100 with the prescaler at count 2
    mode = 2'd0;
    step("t4_off");
    mode = 2'd2;
    step("t4_load");
    for (int i = 0; i < 10; i++) step("t4_run");
    chk("t4_pre_freeze_a", led_a, 4'b0100);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("t4_frozen");
      chk("t4_frozen_a", led_a, 4'h0);
    end
    en = 1'b1;
    step("t4_resume");
    chk("t4_resume_a", led_a, 4'b0100);
    step("t4_resume");
    step("t4_resume");
    chk("t4_next_step_a", led_a, 4'b1000);

    // 5. BLINK -> CHASE on a tick cycle of dut_a
    mode = 2'd1;
    step("t5_load");
    for (int i = 0; i < 3; i++) step("t5_blink");
    mode = 2'd2;
    step("t5_collide");
    step("t5_chase");
    chk("t5_chase_init_a", led_a, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step("t5_hold");
      chk("t5_hold_a", led_a, 4'b0001);
    end
    step("t5_step");
    chk("t5_restart_step_a", led_a, 4'b0010);

    // 6. async reset mid-breathe, asserted between edges
    mode = 2'd3;
    for (int i = 0; i < 23; i++) step("t6_breathe");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_a", led_a, 4'h0);
    chk("t6_async_b", led_b, 4'h0);
    step("t6_in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step("t6_after");

    // random phase
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED pattern generator, the board-level successor to the fixed 4-LED blink top. It drives N_LED outputs from a single clock, using a programmable step prescaler and four run-time selectable modes: off, blink, chase and breathe (PWM). It sits directly behind the top-level `led` pins. Mode and enable come from switches or a control register.

## Interface
- `N_LED`, 4: number of LED channels; must be at least 2.
- `TICK_DIV`, 25_000_000: clk cycles per pattern step; must be at least 1.
- `PWM_BITS`, 8: PWM counter and duty width for breathe mode; must be at least 1.

- `clk`, in, 1: system clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `en`, in, 1: run enable. Low freezes all state and forces `led` to 0.
- `mode`, in, 2: 0 = OFF, 1 = BLINK, 2 = CHASE, 3 = BREATHE. Sampled every cycle.
- `led`, out, N_LED: registered LED drive, active-high.

## Operation
- **Prescaler:** `div_cnt` counts 0..TICK_DIV-1 while `en`=1 and wraps to 0.
  - `tick` = (`div_cnt` == TICK_DIV-1) && `en`.
  - TICK_DIV=1 gives a tick on every enabled cycle.
- **Mode register:** `mode_q` holds the active mode. When `mode` != `mode_q` (checked regardless of `en`), in that cycle:
  - `mode_q` <= `mode`;
  - `div_cnt` <= 0;
  - pattern state reloads its initial values (below);
  - no tick is honoured in that cycle.
- **Pattern state and per-tick update (active `mode_q` only):**
  - OFF: nothing updates.
  - BLINK: `blink` toggles. Initial value 0.
  - CHASE: `chase` rotates left by 1; the MSB wraps into the LSB. Initial value is one-hot bit 0.
  - BREATHE: `duty` steps ±1 as a triangle, with initial value 0 and direction up.
    - Going up: at 2^PWM_BITS-1, direction flips and `duty` decrements on the same tick.
    - Going down: at 0, direction flips and `duty` increments on the same tick.
    - The sequence never holds at an extreme.
- **PWM counter:** `pwm_cnt` (PWM_BITS wide) free-runs, +1 per enabled cycle, wrapping.
- **Output function `f`:**
  - OFF: 0.
  - BLINK: all bits = `blink`.
  - CHASE: `chase`.
  - BREATHE: all bits = (`pwm_cnt` < `duty`).
  - `en`=0: 0.
- **Frozen state:** while `en`=0, `div_cnt`, `pwm_cnt` and the pattern state all hold. Re-asserting `en` resumes exactly where they stopped.

## Timing
- **Reset values:** `led`=0, `div_cnt`=0, `pwm_cnt`=0, `mode_q`=0 (OFF), `blink`=0, `chase`=1, `duty`=0, direction up.
- **Output latency:** `led` <= f(state) every cycle, so there is 1 cycle of output latency after any state change.
- **First step:** the first tick occurs on the TICK_DIV-th enabled cycle after a mode load or reset release. The step is visible on `led` one cycle later.
- **Mode change:** the new mode's initial pattern appears on `led` 2 cycles after `mode` changes (one cycle to load `mode_q`, one for the output register).
- **Simultaneous events:** a mode change and a tick in the same cycle resolve to the mode reload; the tick is dropped.
- **Reset mid-operation:** all registers return to their reset values immediately. `led` goes to 0 asynchronously.
- **Duty range:** duty 0 gives a constant-low output. Duty max gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.

## Structure
- **Package `led_pkg`:** holds the mode constants MODE_OFF, MODE_BLINK, MODE_CHASE and MODE_BREATHE, plus the mode width constant (2).
- **Sub-module `tick_gen`:** parameter DIV; ports `clk`, `rst_n`, `en`, `clr`, `tick`. It owns `div_cnt`.
- **Top:** `led_pattern_gen` holds `mode_q`, the pattern state, `pwm_cnt` and the output register.

## Test plan
1. **Reset, blink.** Settings: N_LED=4, TICK_DIV=4, `mode`=1, `en`=1, release `rst_n`. Required: `led` is 0000 until the cycle after the first tick, then 1111, then toggles every 4 cycles.
2. **Chase wrap.** Settings: `mode`=2, TICK_DIV=1. Required: after the 2-cycle mode load, `led` steps 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
3. **Breathe triangle.** Settings: PWM_BITS=2, TICK_DIV=4, `mode`=3. Required: `duty` follows 0,1,2,3,2,1,0,1; at `duty`=3 exactly 3 of every 4 cycles have `led`=1111.
4. **Enable freeze.** Setup: chase at 0100 with `div_cnt`=2; drop `en` for 10 cycles. Required: `led`=0000 throughout. After `en` rises, `led` shows 0100 next cycle, and 1000 appears 2 enabled cycles later.
5. **Mode change colliding with a tick.** Stimulus: switch BLINK to CHASE on a tick cycle. Required: the tick is ignored, `led`=0001 two cycles later, and `div_cnt` restarts from 0.
6. **Async reset mid-pattern.** Stimulus: pull `rst_n` low between clock edges during breathe. Required: `led`=0 before the next edge; all state returns to reset values.
